// File: rtl/rtc_irq_ctrl.sv
// RTC interrupt controller: sticky w1c event flags, masked pending, level/pulse
// CPU interrupt, and per-event saturating missed-event counters.

module rtc_irq_evt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             event_i,
  input  logic             clear_i,
  input  logic             mask_i,
  input  logic             cnt_clr_i,
  output logic             flag_o,
  output logic             pend_o,
  output logic             pend_nxt_o,
  output logic             rise_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic flag_nxt;

  // event beats a same-cycle clear so a strobe is never lost
  assign flag_nxt   = event_i | (flag_o & ~clear_i);
  assign pend_nxt_o = flag_nxt & mask_i;
  assign rise_o     = pend_nxt_o & ~pend_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flag_o <= 1'b0;
      pend_o <= 1'b0;
      cnt_o  <= '0;
    end else begin
      flag_o <= flag_nxt;
      pend_o <= pend_nxt_o;
      if (cnt_clr_i)
        cnt_o <= '0;
      else if (event_i && flag_o && !clear_i && !(&cnt_o))
        cnt_o <= cnt_o + CNT_W'(1);
    end
  end
endmodule

module rtc_irq_ctrl #(
  parameter int NUM_EVT = 2,
  parameter int PULSE_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_EVT-1:0]       event_i,
  input  logic [NUM_EVT-1:0]       clear_i,
  input  logic [NUM_EVT-1:0]       mask_i,
  input  logic                     mode_i,
  input  logic                     cnt_clr_i,
  output logic [NUM_EVT-1:0]       flags_o,
  output logic [NUM_EVT-1:0]       pending_o,
  output logic                     irq_o,
  output logic [NUM_EVT*CNT_W-1:0] miss_cnt_o
);
  localparam int PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} state_t;

  logic [NUM_EVT-1:0]            pend_nxt, rise;
  logic [NUM_EVT-1:0][CNT_W-1:0] miss_cnt;
  state_t                        state_q, state_d;
  logic [PCW-1:0]                pcnt_q, pcnt_d;
  logic                          rearm_q, rearm_d, mode_q, irq_d, any_rise, mode_chg;

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
    rtc_irq_evt #(.CNT_W(CNT_W)) u_evt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .event_i    (event_i[k]),
      .clear_i    (clear_i[k]),
      .mask_i     (mask_i[k]),
      .cnt_clr_i  (cnt_clr_i),
      .flag_o     (flags_o[k]),
      .pend_o     (pending_o[k]),
      .pend_nxt_o (pend_nxt[k]),
      .rise_o     (rise[k]),
      .cnt_o      (miss_cnt[k])
    );
  end

  assign miss_cnt_o = miss_cnt;
  assign any_rise   = |rise;
  assign mode_chg   = mode_i != mode_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      rearm_q <= 1'b0;
      mode_q  <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      rearm_q <= rearm_d;
      mode_q  <= mode_i;
      irq_o   <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    rearm_d = rearm_q;
    // a mode switch never fires on pending bits that were already set
    if (mode_chg || !mode_i) begin
      state_d = IDLE;
      pcnt_d  = '0;
      rearm_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_rise) begin
          state_d = PULSE;
          pcnt_d  = PCW'(PULSE_W - 1);
        end
        PULSE: begin
          if (any_rise) rearm_d = 1'b1;
          if (pcnt_q == '0) state_d = GAP;
          else              pcnt_d  = pcnt_q - PCW'(1);
        end
        GAP: if (rearm_q || any_rise) begin
          state_d = PULSE;
          pcnt_d  = PCW'(PULSE_W - 1);
          rearm_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    irq_d = mode_i ? (state_d == PULSE) : (|pend_nxt);
  end
endmodule

// File: tb/tb_rtc_irq_ctrl.sv
// Bench for rtc_irq_ctrl: fixed vector table, directed corner sequences and
// randomized traffic checked against a cycle-level behavioural model.

module tb_rtc_irq_ctrl;
  localparam int NE = 2, PW = 4, CW = 8, CMAX = 255;

  logic          clk = 1'b0;
  logic          rst, mode, cnt_clr;
  logic [NE-1:0] ev, clr, mask;
  logic [NE-1:0] flags, pend;
  logic          irq;
  logic [NE*CW-1:0] miss;

  rtc_irq_ctrl #(.NUM_EVT(NE), .PULSE_W(PW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .event_i(ev), .clear_i(clr), .mask_i(mask),
    .mode_i(mode), .cnt_clr_i(cnt_clr), .flags_o(flags), .pending_o(pend),
    .irq_o(irq), .miss_cnt_o(miss)
  );

  always #5 clk = ~clk;

  int npass = 0, ntot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // behavioural model: flags/pending/counters as plain values, irq as a
  // remaining-high-cycles countdown with a one-cycle gap and a queued retrigger
  bit [NE-1:0] mf, mp;
  int          mc [NE];
  bit          mirq, mpmode, mgap, mq;
  int          hi;

  task automatic model_step();
    bit [NE-1:0] nf, np, r;
    if (rst) begin
      mf = 0; mp = 0; mirq = 0; mpmode = 0; hi = 0; mgap = 0; mq = 0;
      for (int k = 0; k < NE; k++) mc[k] = 0;
      return;
    end
    nf = ev | (mf & ~clr);
    for (int k = 0; k < NE; k++)
      if (cnt_clr) mc[k] = 0;
      else if (ev[k] && mf[k] && !clr[k] && mc[k] < CMAX) mc[k]++;
    np = nf & mask;
    r  = np & ~mp;
    if (mode != mpmode || !mode) begin
      hi = 0; mgap = 0; mq = 0;
      mirq = mode ? 1'b0 : (np != 0);
    end else if (hi > 0) begin
      if (r != 0) mq = 1;
      hi--;
      if (hi == 0) mgap = 1;
      mirq = (hi > 0);
    end else if (mgap) begin
      mgap = 0;
      if (mq || r != 0) begin hi = PW; mq = 0; mirq = 1; end
      else mirq = 0;
    end else if (r != 0) begin
      hi = PW; mirq = 1;
    end else mirq = 0;
    mf = nf; mp = np; mpmode = mode;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] e, input logic [1:0] c,
                       input logic [1:0] m, input logic md, input logic cc);
    rst = r; ev = e; clr = c; mask = m; mode = md; cnt_clr = cc;
  endtask

  typedef struct {
    logic r; logic [1:0] e, c, m; logic md;
    logic [1:0] ef, ep; logic ei;
  } vec_t;
  vec_t tbl [12];

  int hcnt;

  initial begin
    tbl[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[2]  = '{1'b0, 2'b01, 2'b00, 2'b11, 1'b0, 2'b01, 2'b01, 1'b1};
    tbl[3]  = '{1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 2'b01, 2'b01, 1'b1};
    tbl[4]  = '{1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 2'b01, 2'b01, 1'b1};
    tbl[5]  = '{1'b0, 2'b00, 2'b01, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0};
    tbl[7]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0};
    tbl[8]  = '{1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 2'b01, 2'b01, 1'b1};
    tbl[9]  = '{1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[10] = '{1'b0, 2'b11, 2'b11, 2'b10, 1'b0, 2'b11, 2'b10, 1'b1};
    tbl[11] = '{1'b0, 2'b00, 2'b11, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0};

    drive(1, 0, 0, 0, 0, 0);
    #1;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].m, tbl[i].md, 1'b0);
      tick();
      chk($sformatf("tbl%0d flags", i), 32'(flags), 32'(tbl[i].ef));
      chk($sformatf("tbl%0d pend", i), 32'(pend), 32'(tbl[i].ep));
      chk($sformatf("tbl%0d irq", i), 32'(irq), 32'(tbl[i].ei));
      if (i < 2) chk($sformatf("tbl%0d miss", i), 32'(miss), 32'd0);
    end

    // event/clear collision keeps the flag and does not count as a miss
    drive(1, 0, 0, 2'b11, 0, 0); tick();
    drive(0, 2'b10, 0, 2'b11, 0, 0); tick();
    drive(0, 2'b10, 2'b10, 2'b11, 0, 0); tick();
    chk("coll flag", 32'(flags), 32'h2);
    chk("coll miss1", 32'(miss[CW +: CW]), 32'd0);
    drive(0, 2'b10, 0, 2'b11, 0, 0); tick();
    chk("miss1 after event", 32'(miss[CW +: CW]), 32'd1);

    // saturation, then clear wins over a same-cycle increment
    drive(1, 0, 0, 2'b11, 0, 0); tick();
    for (int i = 0; i < 300; i++) begin drive(0, 2'b01, 0, 2'b11, 0, 0); tick(); end
    chk("miss0 saturated", 32'(miss[0 +: CW]), 32'd255);
    drive(0, 2'b01, 0, 2'b11, 0, 1); tick();
    chk("miss0 cnt_clr", 32'(miss[0 +: CW]), 32'd0);

    // pulse mode with a retrigger during the first pulse
    drive(1, 0, 0, 2'b11, 1, 0); tick();
    drive(0, 0, 0, 2'b11, 1, 0); tick();
    chk("pulse idle irq", 32'(irq), 32'd0);
    for (int i = 0; i < 11; i++) begin
      logic [10:0] pat;
      pat = 11'b00111101111;
      drive(0, (i == 0) ? 2'b01 : (i == 2) ? 2'b10 : 2'b00, 0, 2'b11, 1, 0);
      tick();
      chk($sformatf("pulse t0+%0d", i + 1), 32'(irq), 32'(pat[i]));
    end

    // masked event then unmask fires one pulse
    drive(0, 0, 2'b11, 2'b11, 1, 0); tick();
    drive(0, 2'b01, 0, 2'b00, 1, 0); tick();
    chk("masked flags", 32'(flags), 32'h1);
    chk("masked pend", 32'(pend), 32'h0);
    chk("masked irq", 32'(irq), 32'h0);
    drive(0, 0, 0, 2'b01, 1, 0); tick();
    chk("unmask pend", 32'(pend), 32'h1);
    chk("unmask irq", 32'(irq), 32'h1);
    hcnt = 0;
    for (int i = 0; i < 8; i++) begin tick(); hcnt += int'(irq); end
    chk("unmask pulse len", 32'(hcnt), 32'd3);

    // reset in the middle of a pulse
    drive(0, 0, 2'b11, 2'b11, 1, 0); tick();
    drive(0, 2'b01, 0, 2'b11, 1, 0); tick();
    drive(0, 2'b01, 0, 2'b11, 1, 0); tick();
    chk("pre-rst irq", 32'(irq), 32'h1);
    drive(1, 0, 0, 2'b11, 1, 0); tick();
    chk("rst irq", 32'(irq), 32'h0);
    chk("rst flags", 32'(flags), 32'h0);
    chk("rst miss", 32'(miss), 32'h0);
    hcnt = 0;
    for (int i = 0; i < 8; i++) begin drive(0, 0, 0, 2'b11, 1, 0); tick(); hcnt += int'(irq); end
    chk("no residual pulse", 32'(hcnt), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic [1:0] nm;
      logic       nmd;
      nm  = ($urandom_range(0, 15) == 0) ? 2'($urandom) : mask;
      nmd = ($urandom_range(0, 40) == 0) ? ~mode : mode;
      drive(($urandom_range(0, 99) == 0), 2'($urandom & $urandom), 2'($urandom & $urandom),
            nm, nmd, ($urandom_range(0, 60) == 0));
      tick();
      chk($sformatf("rnd%0d flags", i), 32'(flags), 32'(mf));
      chk($sformatf("rnd%0d pend", i), 32'(pend), 32'(mp));
      chk($sformatf("rnd%0d irq", i), 32'(irq), 32'(mirq));
      chk($sformatf("rnd%0d miss", i), 32'(miss), {16'd0, mc[1][7:0], mc[0][7:0]});
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
